// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2^m) power engine: defaults, FSM states and
// a generic squarer reduced modulo an arbitrary irreducible polynomial.
package gf_pkg;

   localparam int         FIELD_W_DEF = 6;
   localparam logic [6:0] POLY_DEF    = 7'h43;
   localparam int         GF_MAX_W    = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Squaring is linear in GF(2): spread bits to even positions, then reduce.
   function automatic logic [GF_MAX_W-1:0] gf_sq(
      input logic [GF_MAX_W-1:0] a,
      input logic [GF_MAX_W:0]   poly,
      input int                  field_w
   );
      logic [2*GF_MAX_W-1:0] p;
      p = '0;
      for (int i = 0; i < GF_MAX_W; i++) begin
         p[2*i] = a[i];
      end
      for (int i = 2*GF_MAX_W-1; i >= 0; i--) begin
         if (i >= field_w && p[i]) begin
            p = p ^ ({{(GF_MAX_W-1){1'b0}}, poly} << (i - field_w));
         end else begin
            p = p;
         end
      end
      return p[GF_MAX_W-1:0];
   endfunction

endpackage

// File: rtl/gf_mul.sv
// Combinational GF(2^FIELD_W) multiplier: shift-and-add with the shifted
// operand reduced modulo POLY at every step.
module gf_mul
   import gf_pkg::*;
#(
   parameter int               FIELD_W = FIELD_W_DEF,
   parameter logic [FIELD_W:0] POLY    = POLY_DEF
) (
   input  logic [FIELD_W-1:0] a,
   input  logic [FIELD_W-1:0] b,
   output logic [FIELD_W-1:0] c
);

   logic [FIELD_W-1:0] sum_s;
   logic [FIELD_W-1:0] sh_s;

   // Accumulate a*x^i for each set bit of b, keeping a*x^i reduced
   always_comb begin
      sum_s = '0;
      sh_s  = a;
      for (int i = 0; i < FIELD_W; i++) begin
         if (b[i]) begin
            sum_s = sum_s ^ sh_s;
         end else begin
            sum_s = sum_s;
         end
         if (sh_s[FIELD_W-1]) begin
            sh_s = (sh_s << 1) ^ POLY[FIELD_W-1:0];
         end else begin
            sh_s = sh_s << 1;
         end
      end
      c = sum_s;
   end

endmodule

// File: rtl/gf64_power_engine.sv
// Sequential y = x^d engine over GF(2^FIELD_W): MSB-first square-and-multiply,
// one exponent bit per clock, with valid/ready handshakes on both sides.
module gf64_power_engine
   import gf_pkg::*;
#(
   parameter int               FIELD_W = FIELD_W_DEF,
   parameter logic [FIELD_W:0] POLY    = POLY_DEF,
   parameter int               EXP_W   = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [FIELD_W-1:0] in_x,
   input  logic [EXP_W-1:0]   in_d,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [FIELD_W-1:0] out_y,
   output logic               busy
);

   localparam int CNT_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

   state_t             state_r;
   logic [FIELD_W-1:0] acc_r;
   logic [FIELD_W-1:0] x_r;
   logic [EXP_W-1:0]   d_r;
   logic [CNT_W-1:0]   cnt_r;

   logic [FIELD_W-1:0] sq_s;
   logic [FIELD_W-1:0] prod_s;
   logic [FIELD_W-1:0] next_acc_s;

   assign sq_s = FIELD_W'(gf_sq(GF_MAX_W'(acc_r), (GF_MAX_W+1)'(POLY), FIELD_W));

   gf_mul #(
      .FIELD_W (FIELD_W),
      .POLY    (POLY)
   ) u_mul (
      .a (sq_s),
      .b (x_r),
      .c (prod_s)
   );

   assign next_acc_s = d_r[cnt_r] ? prod_s : sq_s;

   // Control FSM, bit counter and datapath registers; all outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         acc_r     <= '0;
         x_r       <= '0;
         d_r       <= '0;
         cnt_r     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_y     <= '0;
         busy      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid && in_ready) begin
                  x_r      <= in_x;
                  d_r      <= in_d;
                  acc_r    <= FIELD_W'(1);
                  cnt_r    <= CNT_W'(EXP_W - 1);
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state_r  <= RUN;
               end else begin
                  state_r <= IDLE;
               end
            end
            RUN: begin
               acc_r <= next_acc_s;
               if (cnt_r == '0) begin
                  out_valid <= 1'b1;
                  out_y     <= next_acc_s;
                  state_r   <= DONE;
               end else begin
                  cnt_r <= cnt_r - CNT_W'(1);
               end
            end
            DONE: begin
               // in_ready rises only after leaving DONE, so no pop/accept overlap
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state_r   <= IDLE;
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gf64_power_engine.sv
// Directed and sweep checks of gf64_power_engine for moduli 0x43 and 0x49.
module tb_gf64_power_engine;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [5:0] in_x;
   logic [5:0] in_d;
   logic       out_ready;
   logic       in_ready,  out_valid,  busy;
   logic [5:0] out_y;
   logic       in_ready_b, out_valid_b, busy_b;
   logic [5:0] out_y_b;

   int nchk = 0;
   int nerr = 0;
   int cyc  = 0;
   int acc_cyc;

   gf64_power_engine dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_d(in_d), .out_valid(out_valid), .out_ready(out_ready),
      .out_y(out_y), .busy(busy)
   );

   gf64_power_engine #(.POLY(7'h49)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_x(in_x), .in_d(in_d), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_y(out_y_b), .busy(busy_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input int obs, input int exp);
      nchk++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: full carry-less product then long division by poly
   function automatic logic [5:0] m_mul(input logic [5:0] a, input logic [5:0] b,
                                        input logic [6:0] poly);
      logic [11:0] p;
      p = 12'h000;
      for (int i = 0; i < 6; i++) if (b[i]) p = p ^ ({6'b0, a} << i);
      for (int i = 11; i >= 6; i--) if (p[i]) p = p ^ ({5'b0, poly} << (i - 6));
      return p[5:0];
   endfunction

   function automatic logic [5:0] m_pow(input logic [5:0] x, input logic [5:0] d,
                                        input logic [6:0] poly);
      logic [5:0] r;
      r = 6'h01;
      for (int k = 0; k < int'(d); k++) r = m_mul(r, x, poly);
      return r;
   endfunction

   task automatic run_op(input logic [5:0] x, input logic [5:0] d, input logic ordy,
                         output logic [5:0] ya, output logic [5:0] yb, output int lat);
      int n;
      @(negedge clk);
      in_x = x; in_d = d; in_valid = 1'b1; out_ready = ordy;
      n = 0;
      while (!in_ready && n < 40) begin @(negedge clk); n++; end
      acc_cyc = cyc;
      @(negedge clk);
      in_valid = 1'b0; in_x = ~x; in_d = ~d;
      lat = 1;
      while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
      ya = out_y;
      yb = out_y_b;
   endtask

   logic [5:0] vx [7] = '{6'h02, 6'h02, 6'h01, 6'h02, 6'h00, 6'h00, 6'h2A};
   logic [5:0] vd [7] = '{6'd6,  6'd40, 6'd63, 6'd63, 6'd0,  6'd5,  6'd0};
   logic [5:0] vy [7] = '{6'h03, 6'h2F, 6'h01, 6'h01, 6'h01, 6'h00, 6'h01};

   initial begin
      logic [5:0] ya, yb;
      int lat, prev, nv;

      rst = 1'b1; in_valid = 1'b0; in_x = 6'h00; in_d = 6'h00; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_val("rst_in_ready", in_ready, 1);
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_out_y", out_y, 0);
      rst = 1'b0;

      // Directed vectors, back-to-back with out_ready high
      prev = 0;
      for (int i = 0; i < 7; i++) begin
         run_op(vx[i], vd[i], 1'b1, ya, yb, lat);
         check_val($sformatf("vec%0d_y", i), ya, vy[i]);
         check_val($sformatf("vec%0d_lat", i), lat, 7);
         if (i > 0) check_val($sformatf("vec%0d_spacing", i), acc_cyc - prev, 8);
         prev = acc_cyc;
      end

      // Backpressure in DONE with a new request already waiting
      run_op(6'h02, 6'd6, 1'b0, ya, yb, lat);
      check_val("bp_y", ya, 6'h03);
      in_valid = 1'b1; in_x = 6'h3F; in_d = 6'h3F;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_val("bp_hold_y", out_y, 6'h03);
         check_val("bp_hold_valid", out_valid, 1);
         check_val("bp_hold_ready", in_ready, 0);
         check_val("bp_hold_busy", busy, 1);
      end
      out_ready = 1'b1;
      check_val("bp_pop_ready", in_ready, 0);
      @(negedge clk);
      check_val("bp_after_ready", in_ready, 1);
      check_val("bp_after_valid", out_valid, 0);
      check_val("bp_after_y", out_y, 6'h03);
      lat = 0;
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         lat++;
      end while (!out_valid && lat < 40);
      check_val("held_req_lat", lat, 7);
      check_val("held_req_y", out_y, 6'h01);

      // Abort with reset in the third RUN cycle
      @(negedge clk);
      nv = 0;
      while (!in_ready && nv < 40) begin @(negedge clk); nv++; end
      in_x = 6'h02; in_d = 6'd40; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_val("abort_busy_before", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("abort_in_ready", in_ready, 1);
      check_val("abort_out_valid", out_valid, 0);
      check_val("abort_out_y", out_y, 0);
      check_val("abort_busy", busy, 0);
      nv = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) nv++;
      end
      check_val("abort_no_result", nv, 0);
      run_op(6'h03, 6'd1, 1'b1, ya, yb, lat);
      check_val("abort_next_y", ya, 6'h03);

      // Exhaustive sweep against the reference model for both moduli
      for (int x = 0; x < 64; x++) begin
         for (int d = 0; d < 64; d++) begin
            run_op(6'(x), 6'(d), 1'b1, ya, yb, lat);
            check_val($sformatf("sw43 x=%0h d=%0d", x, d), ya, m_pow(6'(x), 6'(d), 7'h43));
            check_val($sformatf("sw49 x=%0h d=%0d", x, d), yb, m_pow(6'(x), 6'(d), 7'h49));
         end
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
